// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_pkg : shared Wishbone bridge types, defaults and lane helpers    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } bridge_state_t;

   localparam int unsigned C_TIMEOUT_DEFAULT = 255;

   // Little-endian lanes: lane 0 is bits [7:0].
   function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

   function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_if : Wishbone classic bus, data width DW (8 or 32)               |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface wb_if #(
   parameter int DW = 32
) ();
   localparam int SW = DW / 8;

   logic [31:0]   adr;
   logic [DW-1:0] dat_w;
   logic [DW-1:0] dat_r;
   logic [SW-1:0] sel;
   logic          we;
   logic          cyc;
   logic          stb;
   logic          ack;
   logic          err;
   logic          rty;

   modport slave8 (
      input  adr, dat_w, sel, we, cyc, stb,
      output dat_r, ack, err, rty
   );

   modport master32 (
      output adr, dat_w, sel, we, cyc, stb,
      input  dat_r, ack, err, rty
   );
endinterface
`default_nettype wire

// File: rtl/wb_word_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_word_buf : one-word tagged read buffer with byte write-through   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module wb_word_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_flush,
   input  logic        i_fill,
   input  logic        i_wr,
   input  logic [29:0] i_tag,
   input  logic [31:0] i_fill_data,
   input  logic [1:0]  i_wr_lane,
   input  logic [7:0]  i_wr_byte,
   input  logic [29:0] i_look_tag,
   output logic        o_hit,
   output logic [31:0] o_data
);
   logic        r_valid;
   logic [29:0] r_tag;
   logic [31:0] r_data;

   assign o_hit  = r_valid && (r_tag == i_look_tag);
   assign o_data = r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else begin
         if (i_fill) begin
            r_tag  <= i_tag;
            r_data <= i_fill_data;
         end else if (i_wr && r_valid && (r_tag == i_tag)) begin
            r_data[{i_wr_lane, 3'b000} +: 8] <= i_wr_byte;
         end
         // A flush in the same clock as a fill leaves the buffer invalid.
         if (i_flush)
            r_valid <= 1'b0;
         else if (i_fill)
            r_valid <= 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/wb_8to32_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_8to32_bridge : 8-bit Wishbone master to 32-bit Wishbone slave    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module wb_8to32_bridge
   import wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = C_TIMEOUT_DEFAULT,
   parameter bit          PREFETCH_EN    = 1'b1
) (
   input  logic   clk_i,
   input  logic   rst_n_i,
   wb_if.slave8   wb_m,
   wb_if.master32 wb_s,
   input  logic   inv_i
);
   localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   bridge_state_t r_state;
   logic [15:0]   r_cnt;
   logic [31:0]   r_adr;
   logic          r_we;
   logic [7:0]    r_byte;

   logic          r_s_cyc;
   logic          r_s_we;
   logic [29:0]   r_s_adr;
   logic [3:0]    r_s_sel;
   logic [31:0]   r_s_dat;

   logic          r_m_ack;
   logic          r_m_err;
   logic          r_m_rty;
   logic [7:0]    r_m_dat;

   logic          w_req;
   logic          w_buf_hit;
   logic [31:0]   w_buf_data;
   logic          w_hit;
   logic          w_in_bus;
   logic          w_m_drop;
   logic          w_s_resp;
   logic          w_timeout;
   logic          w_fill;
   logic          w_wr_upd;
   logic          w_flush;

   assign w_req     = wb_m.cyc & wb_m.stb & wb_m.sel[0];
   assign w_hit     = w_buf_hit & ~wb_m.we;
   assign w_in_bus  = (r_state == BUS);
   assign w_m_drop  = w_in_bus & ~wb_m.cyc;
   assign w_s_resp  = w_in_bus & ~w_m_drop & (wb_s.ack | wb_s.err | wb_s.rty);
   assign w_timeout = w_in_bus & ~w_m_drop & ~w_s_resp & (r_cnt == C_TO_LAST);
   assign w_fill    = PREFETCH_EN && w_s_resp && wb_s.ack && !r_we;
   assign w_wr_upd  = w_s_resp & wb_s.ack & r_we;
   assign w_flush   = inv_i | w_m_drop | w_timeout | (w_s_resp & ~wb_s.ack);

   generate
      if (PREFETCH_EN) begin : g_buf
         wb_word_buf u_buf (
            .clk         (clk_i),
            .rst_n       (rst_n_i),
            .i_flush     (w_flush),
            .i_fill      (w_fill),
            .i_wr        (w_wr_upd),
            .i_tag       (r_adr[31:2]),
            .i_fill_data (wb_s.dat_r),
            .i_wr_lane   (r_adr[1:0]),
            .i_wr_byte   (r_byte),
            .i_look_tag  (wb_m.adr[31:2]),
            .o_hit       (w_buf_hit),
            .o_data      (w_buf_data)
         );
      end else begin : g_nobuf
         logic w_unused_nobuf;
         assign w_buf_hit      = 1'b0;
         assign w_buf_data     = '0;
         assign w_unused_nobuf = ^{w_flush, w_fill, w_wr_upd};
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_adr   <= '0;
         r_we    <= 1'b0;
         r_byte  <= '0;
         r_s_cyc <= 1'b0;
         r_s_we  <= 1'b0;
         r_s_adr <= '0;
         r_s_sel <= '0;
         r_s_dat <= '0;
         r_m_ack <= 1'b0;
         r_m_err <= 1'b0;
         r_m_rty <= 1'b0;
         r_m_dat <= '0;
      end else begin
         r_m_ack <= 1'b0;
         r_m_err <= 1'b0;
         r_m_rty <= 1'b0;
         r_m_dat <= '0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_adr  <= wb_m.adr;
                  r_we   <= wb_m.we;
                  r_byte <= wb_m.dat_w[7:0];
                  if (w_hit) begin
                     r_state <= RESP;
                     r_m_ack <= 1'b1;
                     r_m_dat <= byte_lane(w_buf_data, wb_m.adr[1:0]);
                  end else begin
                     r_state <= BUS;
                     r_cnt   <= '0;
                     r_s_cyc <= 1'b1;
                     r_s_we  <= wb_m.we;
                     r_s_adr <= wb_m.adr[31:2];
                     // Reads fetch the whole word so neighbouring bytes can hit later.
                     r_s_sel <= (wb_m.we || !PREFETCH_EN) ? lane_onehot(wb_m.adr[1:0]) : 4'b1111;
                     r_s_dat <= wb_m.we ? {4{wb_m.dat_w[7:0]}} : 32'd0;
                  end
               end
            end
            BUS: begin
               if (w_m_drop || w_s_resp || w_timeout) begin
                  r_s_cyc <= 1'b0;
                  r_s_we  <= 1'b0;
                  r_s_adr <= '0;
                  r_s_sel <= '0;
                  r_s_dat <= '0;
               end
               if (w_m_drop) begin
                  r_state <= IDLE;
               end else if (w_s_resp) begin
                  r_state <= RESP;
                  r_m_ack <= wb_s.ack;
                  r_m_err <= ~wb_s.ack & wb_s.err;
                  r_m_rty <= ~wb_s.ack & ~wb_s.err & wb_s.rty;
                  r_m_dat <= (wb_s.ack && !r_we) ? byte_lane(wb_s.dat_r, r_adr[1:0]) : 8'd0;
               end else if (w_timeout) begin
                  r_state <= RESP;
                  r_m_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            RESP: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign wb_s.cyc   = r_s_cyc;
   assign wb_s.stb   = r_s_cyc;
   assign wb_s.we    = r_s_we;
   assign wb_s.adr   = {r_s_adr, 2'b00};
   assign wb_s.sel   = r_s_sel;
   assign wb_s.dat_w = r_s_dat;

   assign wb_m.ack = r_m_ack;
   assign wb_m.err = r_m_err;
   assign wb_m.rty = r_m_rty;

   always_comb begin
      wb_m.dat_r      = '0;
      wb_m.dat_r[7:0] = r_m_dat;
   end
endmodule
`default_nettype wire

// File: tb/tb_wb_8to32_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_8to32_bridge : table-driven bench with response scoreboard    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_wb_8to32_bridge;
   localparam int TO = 8;
   localparam int M_NONE = 0, M_ACK = 1, M_ERR = 2, M_RTY = 3;
   localparam logic [2:0] K_ACK = 3'b001, K_ERR = 3'b010, K_RTY = 3'b100;
   localparam int NV = 15;

   typedef struct {
      bit          inv;
      bit          we;
      logic [31:0] adr;
      logic [7:0]  wdat;
      int          mode;
      logic [31:0] word;
      bit          exp_slv;
      logic [31:0] exp_sadr;
      logic [3:0]  exp_sel;
      logic [31:0] exp_sdat;
      logic [2:0]  exp_kind;
      logic [7:0]  exp_dat;
      bit          chk_dat;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [2:0] kind;
      logic [7:0] dat;
      bit         chk_dat;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic inv   = 1'b0;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   int   n_resp = 0;
   int   s_starts = 0;
   int   s_cyc_clocks = 0;
   logic [31:0] s_adr, s_dat;
   logic [3:0]  s_sel;
   logic        s_we;
   bit          s_prev_cyc = 1'b0;
   int          slv_mode = M_NONE;
   logic [31:0] slv_word = '0;

   vec_t vecs[NV];
   vec_t hv;

   wb_if #(.DW(8))  m_bus ();
   wb_if #(.DW(32)) s_bus ();

   wb_8to32_bridge #(
      .TIMEOUT_CYCLES (TO),
      .PREFETCH_EN    (1'b1)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .wb_m    (m_bus),
      .wb_s    (s_bus),
      .inv_i   (inv)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Master-side monitor: every response pulse is matched against the scoreboard.
   always @(negedge clk) begin
      logic [2:0] k;
      exp_t e;
      k = {m_bus.rty, m_bus.err, m_bus.ack};
      if (k != 3'b000) begin
         n_resp++;
         if (sb_q.size() == 0) begin
            check("unexpected_resp", 32'(k), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("resp_kind", 32'(k), 32'(e.kind));
            if (e.chk_dat)
               check("resp_dat", 32'(m_bus.dat_r), 32'(e.dat));
         end
      end
   end

   // Word slave model: answers on the first clock it sees cyc&stb.
   always @(negedge clk) begin
      s_bus.ack = 1'b0;
      s_bus.err = 1'b0;
      s_bus.rty = 1'b0;
      if (s_bus.cyc === 1'b1 && s_bus.stb === 1'b1) begin
         if (!s_prev_cyc) begin
            s_starts++;
            s_adr = s_bus.adr;
            s_sel = s_bus.sel;
            s_dat = s_bus.dat_w;
            s_we  = s_bus.we;
         end
         s_cyc_clocks++;
         case (slv_mode)
            M_ACK: begin
               s_bus.ack   = 1'b1;
               s_bus.dat_r = slv_word;
            end
            M_ERR: s_bus.err = 1'b1;
            M_RTY: s_bus.rty = 1'b1;
            default: ;
         endcase
      end
      s_prev_cyc = (s_bus.cyc === 1'b1);
   end

   task automatic do_vec(input string tag, input vec_t v);
      int   st0, cc0, r0, lat;
      bit   got;
      exp_t e;
      if (v.inv) begin
         inv = 1'b1;
         @(negedge clk); #1;
         inv = 1'b0;
      end
      slv_mode = v.mode;
      slv_word = v.word;
      st0 = s_starts;
      cc0 = s_cyc_clocks;
      r0  = n_resp;
      e.kind = v.exp_kind;
      e.dat = v.exp_dat;
      e.chk_dat = v.chk_dat;
      sb_q.push_back(e);
      m_bus.adr   = v.adr;
      m_bus.we    = v.we;
      m_bus.dat_w = v.wdat;
      m_bus.sel   = 1'b1;
      m_bus.cyc   = 1'b1;
      m_bus.stb   = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk); #1;
         lat++;
         got = (n_resp != r0);
      end
      m_bus.cyc = 1'b0;
      m_bus.stb = 1'b0;
      m_bus.we  = 1'b0;
      if (!got) begin
         check({tag, " no_response"}, 32'd0, 32'd1);
         sb_q.delete();
      end else begin
         check({tag, " latency"}, lat, v.exp_lat);
      end
      check({tag, " slave_cycles"}, s_starts - st0, v.exp_slv ? 1 : 0);
      if (v.exp_slv) begin
         check({tag, " slave_adr"}, s_adr, v.exp_sadr);
         check({tag, " slave_sel"}, 32'(s_sel), 32'(v.exp_sel));
         check({tag, " slave_we"}, 32'(s_we), 32'(v.we));
         if (v.we)
            check({tag, " slave_dat"}, s_dat, v.exp_sdat);
         if (v.mode == M_NONE)
            check({tag, " slave_cyc_clocks"}, s_cyc_clocks - cc0, TO);
      end
      @(negedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int r0, st0;
      m_bus.adr = '0; m_bus.dat_w = '0; m_bus.sel = '0;
      m_bus.we = 1'b0; m_bus.cyc = 1'b0; m_bus.stb = 1'b0;
      s_bus.ack = 1'b0; s_bus.err = 1'b0; s_bus.rty = 1'b0; s_bus.dat_r = '0;

      //        inv we adr      wdat   mode   word          slv sadr     sel    sdat          kind   dat    chk lat
      vecs[0]  = '{0, 0, 32'h103, 8'h00, M_ACK,  32'hAABBCCDD, 1, 32'h100, 4'hF, 32'h0,        K_ACK, 8'hAA, 1, 2};
      vecs[1]  = '{0, 0, 32'h101, 8'h00, M_NONE, 32'h0,        0, 32'h0,   4'h0, 32'h0,        K_ACK, 8'hCC, 1, 1};
      vecs[2]  = '{0, 1, 32'h102, 8'h55, M_ACK,  32'h0,        1, 32'h100, 4'h4, 32'h55555555, K_ACK, 8'h00, 0, 2};
      vecs[3]  = '{0, 0, 32'h102, 8'h00, M_NONE, 32'h0,        0, 32'h0,   4'h0, 32'h0,        K_ACK, 8'h55, 1, 1};
      vecs[4]  = '{0, 0, 32'h100, 8'h00, M_NONE, 32'h0,        0, 32'h0,   4'h0, 32'h0,        K_ACK, 8'hDD, 1, 1};
      vecs[5]  = '{0, 0, 32'h200, 8'h00, M_ERR,  32'h0,        1, 32'h200, 4'hF, 32'h0,        K_ERR, 8'h00, 0, 2};
      vecs[6]  = '{0, 0, 32'h101, 8'h00, M_ACK,  32'h11223344, 1, 32'h100, 4'hF, 32'h0,        K_ACK, 8'h33, 1, 2};
      vecs[7]  = '{0, 0, 32'h200, 8'h00, M_RTY,  32'h0,        1, 32'h200, 4'hF, 32'h0,        K_RTY, 8'h00, 0, 2};
      vecs[8]  = '{0, 0, 32'h103, 8'h00, M_ACK,  32'hAABBCCDD, 1, 32'h100, 4'hF, 32'h0,        K_ACK, 8'hAA, 1, 2};
      vecs[9]  = '{0, 0, 32'h20C, 8'h00, M_NONE, 32'h0,        1, 32'h20C, 4'hF, 32'h0,        K_ERR, 8'h00, 0, 9};
      vecs[10] = '{0, 0, 32'h102, 8'h00, M_ACK,  32'h99887766, 1, 32'h100, 4'hF, 32'h0,        K_ACK, 8'h88, 1, 2};
      vecs[11] = '{0, 0, 32'h100, 8'h00, M_NONE, 32'h0,        0, 32'h0,   4'h0, 32'h0,        K_ACK, 8'h66, 1, 1};
      vecs[12] = '{1, 0, 32'h100, 8'h00, M_ACK,  32'hCAFEF00D, 1, 32'h100, 4'hF, 32'h0,        K_ACK, 8'h0D, 1, 2};
      vecs[13] = '{0, 1, 32'h307, 8'hA5, M_ACK,  32'h0,        1, 32'h304, 4'h8, 32'hA5A5A5A5, K_ACK, 8'h00, 0, 2};
      vecs[14] = '{0, 0, 32'h101, 8'h00, M_NONE, 32'h0,        0, 32'h0,   4'h0, 32'h0,        K_ACK, 8'hF0, 1, 1};

      repeat (3) @(negedge clk);
      #1;
      check("reset s_cyc", 32'(s_bus.cyc), 32'd0);
      check("reset s_stb", 32'(s_bus.stb), 32'd0);
      check("reset s_we",  32'(s_bus.we), 32'd0);
      check("reset s_adr", s_bus.adr, 32'd0);
      check("reset s_sel", 32'(s_bus.sel), 32'd0);
      check("reset s_dat", s_bus.dat_w, 32'd0);
      check("reset m_resp", 32'({m_bus.rty, m_bus.err, m_bus.ack}), 32'd0);
      check("reset m_dat", 32'(m_bus.dat_r), 32'd0);
      rst_n = 1'b1;
      @(negedge clk); #1;

      for (int i = 0; i < NV; i++)
         do_vec($sformatf("v%0d", i), vecs[i]);

      // Master abandons the cycle while the slave is silent.
      slv_mode = M_NONE;
      r0  = n_resp;
      st0 = s_starts;
      m_bus.adr = 32'h400; m_bus.we = 1'b0; m_bus.sel = 1'b1;
      m_bus.cyc = 1'b1; m_bus.stb = 1'b1;
      repeat (3) begin @(negedge clk); #1; end
      check("drop s_cyc_before", 32'(s_bus.cyc), 32'd1);
      m_bus.cyc = 1'b0; m_bus.stb = 1'b0;
      @(negedge clk); #1;
      check("drop s_cyc_after", 32'({s_bus.cyc, s_bus.stb}), 32'd0);
      repeat (4) @(negedge clk);
      #1;
      check("drop no_response", n_resp - r0, 0);
      check("drop slave_cycles", s_starts - st0, 1);
      hv = '{0, 0, 32'h101, 8'h00, M_ACK, 32'h0BADBEEF, 1, 32'h100, 4'hF, 32'h0, K_ACK, 8'hBE, 1, 2};
      do_vec("drop_refetch", hv);

      // Reset lands in the middle of a slave cycle.
      slv_mode = M_NONE;
      r0 = n_resp;
      m_bus.adr = 32'h500; m_bus.we = 1'b0; m_bus.sel = 1'b1;
      m_bus.cyc = 1'b1; m_bus.stb = 1'b1;
      repeat (2) begin @(negedge clk); #1; end
      check("rst s_cyc_before", 32'(s_bus.cyc), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst s_cyc_now", 32'({s_bus.cyc, s_bus.stb}), 32'd0);
      check("rst m_resp_now", 32'({m_bus.rty, m_bus.err, m_bus.ack}), 32'd0);
      m_bus.cyc = 1'b0; m_bus.stb = 1'b0;
      @(negedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst no_response", n_resp - r0, 0);
      hv = '{0, 0, 32'h101, 8'h00, M_ACK, 32'h76543210, 1, 32'h100, 4'hF, 32'h0, K_ACK, 8'h32, 1, 2};
      do_vec("rst_refetch", hv);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/wb_8to32_bridge.md
WB_8TO32_BRIDGE -- requirements
Module: wb_8to32_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: slave-cycle clocks without ack/err/rty before the bridge aborts; legal range 1..65535.
REQ-002 Parameter PREFETCH_EN, default 1: 1 enables the one-word read buffer, 0 disables it.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 wb_m  wb_if.slave8 modport  --  8-bit Wishbone classic port driven by the byte master; fields adr/dat/sel/we/cyc/stb in, dat(8)/ack/err/rty out.
REQ-006 wb_s  wb_if.master32 modport  --  32-bit Wishbone classic port to the word slave; fields adr/dat(32)/sel(4)/we/cyc/stb out, dat(32)/ack/err/rty in.
REQ-007 inv_i  input  1  one-cycle pulse that flushes the read buffer (DMA coherency).

Function
REQ-008 FSM states: IDLE, BUS, RESP; IDLE is entered on reset.
REQ-009 In IDLE, a request is cyc&stb&sel from the master; with no request, stay in IDLE.
REQ-010 Buffer hit: PREFETCH_EN=1, read, buffer valid, tag equals adr[31:2]; go to RESP, no slave cycle; ack at master one clock after the request is sampled.
REQ-011 On any other request, latch adr/we/byte; go to BUS; wb_s cyc/stb asserted from the next clock.
REQ-012 In BUS, the slave address is {adr[31:2],2'b00}.
REQ-013 In BUS, a write drives slave dat = {4{byte}} and sel = one-hot(adr[1:0]).
REQ-014 In BUS, a read drives sel = 4'b1111 if PREFETCH_EN, else one-hot(adr[1:0]).
REQ-015 Slave ack/err/rty in BUS: drop wb_s cyc/stb on the next clock, capture the response and data, go to RESP.
REQ-016 RESP drives exactly one master ack, err or rty pulse for one clock, then returns to IDLE; no new request is accepted in the RESP clock.
REQ-017 Master read data = the latched word byte selected by adr[1:0]; dat is 0 outside RESP.
REQ-018 Read miss with ack and PREFETCH_EN: store the word and its tag, set valid.
REQ-019 Write ack to the buffered tag: update that byte lane in the buffer (write-through).
REQ-020 Any slave err/rty/timeout clears valid.
REQ-021 Timeout counter: 16 bits, cleared on BUS entry, increments each BUS clock; at TIMEOUT_CYCLES, abort the slave cycle, clear valid, and return master err in RESP.
REQ-022 Master drops cyc during BUS: deassert slave cyc/stb on the next clock, clear valid, go to IDLE, no response pulse.
REQ-023 inv_i clears valid; if inv_i coincides with a read-miss fill, inv_i wins (valid = 0).
REQ-024 Slave ack and timeout in the same clock: ack wins.

Reset
REQ-025 On rst_n_i low, immediately: state IDLE, buffer valid 0, counter 0.
REQ-026 On rst_n_i low, all wb_s outputs and master ack/err/rty/dat are 0.
REQ-027 Reset during BUS drops the slave cycle with no response to either side.

Structure
REQ-028 A bridge_state_t enum and the default TIMEOUT_CYCLES go in the shared wb_pkg.
REQ-029 The wb_if modports slave8 and master32 are added to wb_if if absent.
REQ-030 The read buffer (data, tag, valid, byte-update, flush) is one sub-module, wb_word_buf; the FSM and timeout counter stay in the top.

Verification
REQ-031 Read 0x103 with slave word 0xAABBCCDD -> slave adr 0x100, sel 1111; master dat 0xAA, one ack.
REQ-032 Then read 0x101 -> no slave cyc; master dat 0xCC, ack 1 clock after stb.
REQ-033 Write 0x55 to 0x102 -> slave dat 0x55555555, sel 0100; a following read of 0x102 hits the buffer and returns 0x55.
REQ-034 Slave never answers, TIMEOUT_CYCLES=8 -> slave cyc drops after 8 BUS clocks; master err pulses once; next read of the same word misses.
REQ-035 inv_i pulse between two reads of 0x100 -> second read issues a slave cycle.
REQ-036 Master drops cyc mid-BUS, and rst_n_i low mid-BUS -> slave cyc low next clock (immediately under reset); no ack/err/rty to master.
